// File: rtl/irq_controller_if.sv
// Bus register port and CPU request/acknowledge handshake of the interrupt controller.
// The controller connects to the slave modport; the bus/CPU side connects to master.
interface irq_controller_if;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic [1:0]  cpu_ilevel;
  logic        irq_req;
  logic [1:0]  irq_level;
  logic [7:0]  irq_vector;
  logic        irq_ack;

  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in, cpu_ilevel, irq_ack,
    input  bus_data_out, irq_req, irq_level, irq_vector
  );

  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in, cpu_ilevel, irq_ack,
    output bus_data_out, irq_req, irq_level, irq_vector
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: latches source pulses, arbitrates by group priority and drives a CPU req/ack.
// Define IRQ_SWTRIG_EN to map a write-only software trigger register at BASE_ADDR+3.
module irq_controller #(
  parameter logic [23:0] BASE_ADDR   = 24'h2020,
  parameter logic [7:0]  VECTOR_BASE = 8'h03
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_ce,
  input  logic [7:0]       irqs,
  irq_controller_if.slave  bus
);

  localparam int NUM_SRC = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [7:0]  prio_reg;
  logic [7:0]  enable_reg;
  logic [7:0]  flag_reg;
  logic [2:0]  latched_idx_reg;
  logic        irq_req_reg;
  logic [1:0]  irq_level_reg;
  logic [7:0]  irq_vector_reg;

  logic        wr_en;
  logic        sel_prio;
  logic        sel_enable;
  logic        sel_flags;
  logic [7:0]  flag_clear;
  logic [7:0]  swtrig_set;
  logic [7:0]  flag_next;

  logic [1:0]         src_level [NUM_SRC];
  logic [NUM_SRC-1:0] candidate;
  logic               win_valid;
  logic [2:0]         win_idx;
  logic [1:0]         win_level;

  assign wr_en      = bus.bus_write & clk_ce;
  assign sel_prio   = (bus.bus_address_in == BASE_ADDR);
  assign sel_enable = (bus.bus_address_in == BASE_ADDR + 24'd1);
  assign sel_flags  = (bus.bus_address_in == BASE_ADDR + 24'd2);

  assign flag_clear = (wr_en && sel_flags) ? bus.bus_data_in : 8'h00;

`ifdef IRQ_SWTRIG_EN
  logic sel_swtrig;
  assign sel_swtrig = (bus.bus_address_in == BASE_ADDR + 24'd3);
  assign swtrig_set = (wr_en && sel_swtrig) ? bus.bus_data_in : 8'h00;
`else
  assign swtrig_set = 8'h00;
`endif

  // New pulses are OR-ed in after the clear so a same-cycle set beats a W1C.
  assign flag_next = (flag_reg & ~flag_clear) | irqs | swtrig_set;

  // Sources 2g and 2g+1 share the two PRIO bits of group g.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_level[gi] = prio_reg[2*(gi/2) +: 2];
      assign candidate[gi] = flag_reg[gi] & enable_reg[gi] &
                             (src_level[gi] != 2'd0) &
                             (src_level[gi] > bus.cpu_ilevel);
    end
  endgenerate

  // Scanning downward with >= leaves the lowest index holding any tied top level.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 3'd0;
    win_level = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (candidate[i] && (src_level[i] >= win_level)) begin
        win_valid = 1'b1;
        win_idx   = 3'(i);
        win_level = src_level[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_reg   <= 8'h00;
      enable_reg <= 8'h00;
      flag_reg   <= 8'h00;
    end else if (clk_ce) begin
      if (bus.bus_write && sel_prio) begin
        prio_reg <= bus.bus_data_in;
      end
      if (bus.bus_write && sel_enable) begin
        enable_reg <= bus.bus_data_in;
      end
      flag_reg <= flag_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      latched_idx_reg <= 3'd0;
      irq_req_reg     <= 1'b0;
      irq_level_reg   <= 2'd0;
      irq_vector_reg  <= 8'h00;
    end else if (clk_ce) begin
      case (state_reg)
        ST_IDLE: begin
          if (win_valid) begin
            state_reg       <= ST_REQ;
            irq_req_reg     <= 1'b1;
            latched_idx_reg <= win_idx;
            irq_level_reg   <= win_level;
            irq_vector_reg  <= VECTOR_BASE + {5'd0, win_idx};
          end
        end
        ST_REQ: begin
          if (bus.irq_ack) begin
            state_reg   <= ST_SERVICE;
            irq_req_reg <= 1'b0;
          end else if (!candidate[latched_idx_reg]) begin
            state_reg   <= ST_IDLE;
            irq_req_reg <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (!flag_reg[latched_idx_reg]) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          irq_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_req    = irq_req_reg;
  assign bus.irq_level  = irq_level_reg;
  assign bus.irq_vector = irq_vector_reg;

  // Read data is driven only while the read strobe is high; reads never alter state.
  always_comb begin
    bus.bus_data_out = 8'h00;
    if (bus.bus_read) begin
      if (sel_prio) begin
        bus.bus_data_out = prio_reg;
      end else if (sel_enable) begin
        bus.bus_data_out = enable_reg;
      end else if (sel_flags) begin
        bus.bus_data_out = flag_reg;
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized run
// compared against a priority/handshake reference model kept in the bench.
module tb_irq_controller;

  localparam logic [23:0] BASE = 24'h2020;
  localparam logic [7:0]  VB   = 8'h03;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       clk_ce = 1'b1;
  logic [7:0] irqs   = 8'h00;

  irq_controller_if bus_if();

  irq_controller #(.BASE_ADDR(BASE), .VECTOR_BASE(VB)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .clk_ce (clk_ce),
    .irqs   (irqs),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: registers, plus what the CPU currently sees.
  logic [7:0] m_prio, m_en, m_flags;
  int         m_phase;   // 0 waiting, 1 presenting, 2 being serviced
  int         m_src;
  logic       m_req;
  logic [1:0] m_level;
  logic [7:0] m_vec;

  function automatic int lvl_of(int i);
    return int'(m_prio >> (2 * (i / 2))) & 3;
  endfunction

  function automatic bit is_cand(int i);
    return m_flags[i] && m_en[i] && (lvl_of(i) != 0) && (lvl_of(i) > int'(bus_if.cpu_ilevel));
  endfunction

  function automatic int pick();
    for (int l = 3; l >= 1; l--)
      for (int i = 0; i < 8; i++)
        if (is_cand(i) && lvl_of(i) == l) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_read();
    if (!bus_if.bus_read) return 8'h00;
    if (bus_if.bus_address_in == BASE)          return m_prio;
    if (bus_if.bus_address_in == BASE + 24'd1)  return m_en;
    if (bus_if.bus_address_in == BASE + 24'd2)  return m_flags;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_prio = 0; m_en = 0; m_flags = 0; m_phase = 0; m_src = 0;
    m_req = 0; m_level = 0; m_vec = 0;
  endtask

  task automatic model_step();
    int w;
    logic [7:0] clr, setb;
    if (!clk_ce) return;
    w = pick();
    case (m_phase)
      0: if (w >= 0) begin
           m_phase = 1; m_req = 1; m_src = w;
           m_level = 2'(lvl_of(w));
           m_vec = 8'((int'(VB) + w) % 256);
         end
      1: if (bus_if.irq_ack) begin
           m_phase = 2; m_req = 0;
         end else if (!is_cand(m_src)) begin
           m_phase = 0; m_req = 0;
         end
      default: if (!m_flags[m_src]) m_phase = 0;
    endcase
    clr = 0; setb = irqs;
    if (bus_if.bus_write) begin
      if (bus_if.bus_address_in == BASE)         m_prio = bus_if.bus_data_in;
      if (bus_if.bus_address_in == BASE + 24'd1) m_en = bus_if.bus_data_in;
      if (bus_if.bus_address_in == BASE + 24'd2) clr = bus_if.bus_data_in;
`ifdef IRQ_SWTRIG_EN
      if (bus_if.bus_address_in == BASE + 24'd3) setb = setb | bus_if.bus_data_in;
`endif
    end
    m_flags = (m_flags & ~clr) | setb;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
    bus_if.bus_write = 1'b1;
    bus_if.bus_address_in = a;
    bus_if.bus_data_in = d;
    $display("write addr=%h data=%h irqs=%h ce=%0b", a, d, irqs, clk_ce);
    cycle();
    bus_if.bus_write = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a, output logic [7:0] d);
    bus_if.bus_read = 1'b1;
    bus_if.bus_address_in = a;
    #1;
    d = bus_if.bus_data_out;
    $display("read  addr=%h data=%h", a, d);
  endtask

  task automatic wait_req(input int bound, output bit ok);
    ok = 0;
    for (int n = 0; n < bound && !ok; n++) begin
      cycle();
      if (bus_if.irq_req === 1'b1) ok = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++; if (bus_if.irq_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", bus_if.irq_req); end
    checks++; if (bus_if.irq_vector !== 8'h00 || bus_if.irq_level !== 2'd0) begin errors++;
      $display("FAIL reset_outs: got vec=%h lvl=%0d want 00/0", bus_if.irq_vector, bus_if.irq_level); end
    for (int r = 0; r < 3; r++) begin
      rd(BASE + 24'(r), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h want 00", r, d); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    logic [7:0] d;
    do_reset();
    bus_wr(BASE, 8'h03);
    bus_wr(BASE + 24'd1, 8'h01);
    irqs = 8'h01; cycle(); irqs = 8'h00;
    checks++; if (bus_if.irq_req !== 1'b0) begin errors++; $display("FAIL single_early: got req=%0b want 0", bus_if.irq_req); end
    rd(BASE + 24'd2, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL single_flag: got %h want 01", d); end
    cycle();
    checks++; if (bus_if.irq_req !== 1'b1 || bus_if.irq_level !== 2'd3 || bus_if.irq_vector !== 8'h03) begin errors++;
      $display("FAIL single_req: got req=%0b lvl=%0d vec=%h want 1/3/03", bus_if.irq_req, bus_if.irq_level, bus_if.irq_vector); end
    bus_if.irq_ack = 1'b1; cycle(); bus_if.irq_ack = 1'b0;
    checks++; if (bus_if.irq_req !== 1'b0) begin errors++; $display("FAIL ack_drop: got req=%0b want 0", bus_if.irq_req); end
    cycle();
    checks++; if (bus_if.irq_req !== 1'b0) begin errors++; $display("FAIL service_hold: got req=%0b want 0", bus_if.irq_req); end
    bus_wr(BASE + 24'd2, 8'h01);
    cycle(); cycle();
    checks++; if (bus_if.irq_req !== 1'b0) begin errors++; $display("FAIL after_clear: got req=%0b want 0", bus_if.irq_req); end
    rd(BASE + 24'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL w1c_flag: got %h want 00", d); end
  endtask

  task automatic test_priority();
    bit ok;
    do_reset();
    bus_wr(BASE, 8'h09);
    bus_wr(BASE + 24'd1, 8'h0F);
    irqs = 8'h09; cycle(); irqs = 8'h00;
    wait_req(3, ok);
    checks++; if (!ok || bus_if.irq_vector !== 8'h06 || bus_if.irq_level !== 2'd2) begin errors++;
      $display("FAIL prio_first: got req=%0b vec=%h lvl=%0d want 1/06/2", ok, bus_if.irq_vector, bus_if.irq_level); end
    bus_if.irq_ack = 1'b1; cycle(); bus_if.irq_ack = 1'b0;
    bus_wr(BASE + 24'd2, 8'h08);
    wait_req(5, ok);
    checks++; if (!ok || bus_if.irq_vector !== 8'h03 || bus_if.irq_level !== 2'd1) begin errors++;
      $display("FAIL prio_second: got req=%0b vec=%h lvl=%0d want 1/03/1", ok, bus_if.irq_vector, bus_if.irq_level); end
  endtask

  task automatic test_mask();
    bit ok;
    logic [7:0] d;
    do_reset();
    bus_wr(BASE, 8'h03);
    bus_wr(BASE + 24'd1, 8'h01);
    irqs = 8'h01; cycle(); irqs = 8'h00;
    wait_req(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_req: got req=0 want 1"); end
    bus_if.cpu_ilevel = 2'd3; cycle();
    checks++; if (bus_if.irq_req !== 1'b0) begin errors++; $display("FAIL mask_retract: got req=%0b want 0", bus_if.irq_req); end
    rd(BASE + 24'd2, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL mask_flag: got %h want 01", d); end
    bus_if.cpu_ilevel = 2'd0;
  endtask

  task automatic test_set_wins_and_reset();
    bit ok;
    logic [7:0] d;
    do_reset();
    irqs = 8'h02;
    bus_wr(BASE + 24'd2, 8'h02);
    irqs = 8'h00;
    rd(BASE + 24'd2, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL set_wins: got %h want 02", d); end
    bus_wr(BASE, 8'h03);
    bus_wr(BASE + 24'd1, 8'h02);
    wait_req(3, ok);
    checks++; if (!ok || bus_if.irq_vector !== 8'h04) begin errors++;
      $display("FAIL src1_req: got req=%0b vec=%h want 1/04", ok, bus_if.irq_vector); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus_if.irq_req !== 1'b0 || bus_if.irq_vector !== 8'h00 || bus_if.irq_level !== 2'd0) begin errors++;
      $display("FAIL async_reset: got req=%0b vec=%h lvl=%0d want 0/00/0", bus_if.irq_req, bus_if.irq_vector, bus_if.irq_level); end
    for (int r = 0; r < 3; r++) begin
      rd(BASE + 24'(r), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL async_reg%0d: got %h want 00", r, d); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_clock_enable();
    logic [7:0] d;
    do_reset();
    clk_ce = 1'b0;
    irqs = 8'hFF;
    bus_wr(BASE + 24'd1, 8'hFF);
    irqs = 8'h00;
    clk_ce = 1'b1;
    rd(BASE + 24'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ce_flags: got %h want 00", d); end
    rd(BASE + 24'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ce_enable: got %h want 00", d); end
  endtask

  task automatic test_swtrig();
    bit ok;
    logic [7:0] d;
    do_reset();
    bus_wr(BASE, 8'h40);
    bus_wr(BASE + 24'd1, 8'h80);
    bus_wr(BASE + 24'd3, 8'h80);
`ifdef IRQ_SWTRIG_EN
    wait_req(3, ok);
    checks++; if (!ok || bus_if.irq_vector !== 8'h0A || bus_if.irq_level !== 2'd1) begin errors++;
      $display("FAIL swtrig_req: got req=%0b vec=%h lvl=%0d want 1/0A/1", ok, bus_if.irq_vector, bus_if.irq_level); end
`else
    wait_req(3, ok);
    checks++; if (ok) begin errors++; $display("FAIL swtrig_off_req: got req=1 want 0"); end
    rd(BASE + 24'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL swtrig_off_flag: got %h want 00", d); end
`endif
    rd(BASE + 24'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL base3_read: got %h want 00", d); end
  endtask

  task automatic test_random();
    logic [7:0] exp_rd;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      clk_ce = ($urandom_range(0, 7) != 0);
      irqs = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 19) == 0) bus_if.cpu_ilevel = 2'($urandom_range(0, 3));
      bus_if.irq_ack = bus_if.irq_req && ($urandom_range(0, 2) == 0);
      bus_if.bus_write = ($urandom_range(0, 3) == 0);
      bus_if.bus_read = ($urandom_range(0, 3) != 0);
      bus_if.bus_address_in = ($urandom_range(0, 9) == 0) ? 24'h000020 : BASE + 24'($urandom_range(0, 4));
      bus_if.bus_data_in = 8'($urandom);
      if (bus_if.bus_write)
        $display("rand  n=%0d write addr=%h data=%h ce=%0b", n, bus_if.bus_address_in, bus_if.bus_data_in, clk_ce);
      cycle();
      checks++; if (bus_if.irq_req !== m_req) begin errors++;
        $display("FAIL rand_req n=%0d: got %0b want %0b", n, bus_if.irq_req, m_req); end
      if (m_req) begin
        checks++; if (bus_if.irq_vector !== m_vec || bus_if.irq_level !== m_level) begin errors++;
          $display("FAIL rand_vec n=%0d: got vec=%h lvl=%0d want vec=%h lvl=%0d", n, bus_if.irq_vector, bus_if.irq_level, m_vec, m_level); end
      end
      exp_rd = model_read();
      checks++; if (bus_if.bus_data_out !== exp_rd) begin errors++;
        $display("FAIL rand_read n=%0d addr=%h: got %h want %h", n, bus_if.bus_address_in, bus_if.bus_data_out, exp_rd); end
    end
    clk_ce = 1'b1; irqs = 8'h00; bus_if.irq_ack = 1'b0; bus_if.bus_write = 1'b0; bus_if.cpu_ilevel = 2'd0;
  endtask

  initial begin
    bus_if.bus_write = 1'b0;
    bus_if.bus_read = 1'b0;
    bus_if.bus_address_in = 24'h0;
    bus_if.bus_data_in = 8'h00;
    bus_if.cpu_ilevel = 2'd0;
    bus_if.irq_ack = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_set_wins_and_reset();
    test_clock_enable();
    test_swtrig();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
